// File: rtl/pooling_input_serializer_if.sv
// Stream bundle between the pooling line buffer, the serializer and the pooling comparator.
// Both sides use valid/ready: a beat moves on a rising clk edge where valid and ready are
// both high; valid never waits on ready, and the source holds its data stable until the beat moves.
interface pooling_input_serializer_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int KERNEL_SIZE = 2,
  parameter int CHANNELS    = 1
);
  logic                                    in_valid;
  logic                                    in_ready;
  logic [CHANNELS*KERNEL_SIZE*DATA_WIDTH-1:0] data_in;
  logic                                    out_valid;
  logic                                    out_ready;
  logic [CHANNELS*DATA_WIDTH-1:0]          data_out;
  logic                                    out_first;
  logic                                    out_last;
  logic                                    out_row_last;

  modport master (
    output in_valid, data_in, out_ready,
    input  in_ready, out_valid, data_out, out_first, out_last, out_row_last
  );

  modport slave (
    input  in_valid, data_in, out_ready,
    output in_ready, out_valid, data_out, out_first, out_last, out_row_last
  );
endinterface

// File: rtl/pooling_input_serializer.sv
// Multi-channel parallel-to-serial front end for the pooling comparator: takes one
// KERNEL_SIZE-word group per channel and emits it one word per cycle, all lanes in lockstep.
module pooling_input_serializer #(
  parameter int DATA_WIDTH  = 32,
  parameter int KERNEL_SIZE = 2,
  parameter int CHANNELS    = 1,
  parameter int INPUT_SIZE  = 6
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  pooling_input_serializer_if.slave bus,
  output logic                      dbg_state
);

  localparam int GPR   = INPUT_SIZE / KERNEL_SIZE;
  localparam int IDX_W = $clog2(KERNEL_SIZE);
  localparam int GC_W  = (GPR > 1) ? $clog2(GPR) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(KERNEL_SIZE - 1);
  localparam logic [GC_W-1:0]  LAST_GRP = GC_W'(GPR - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  typedef logic [CHANNELS-1:0][KERNEL_SIZE-1:0][DATA_WIDTH-1:0] stage_t;

  state_e           state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic [IDX_W-1:0] word_idx_q, word_idx_d;
  logic [GC_W-1:0]  group_cnt_q, group_cnt_d;
  stage_t           stage_q, stage_d;

  logic in_ready;
  logic load;
  logic pop;
  logic is_last;

  // Word 0 of every channel slice is its most-significant word.
  function automatic stage_t unpack_group(
    input logic [CHANNELS*KERNEL_SIZE*DATA_WIDTH-1:0] din
  );
    stage_t s;
    for (int c = 0; c < CHANNELS; c++) begin
      for (int k = 0; k < KERNEL_SIZE; k++) begin
        s[c][k] = din[(c*KERNEL_SIZE + (KERNEL_SIZE-1-k))*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    return s;
  endfunction

  function automatic stage_t shift_down(input stage_t s_in);
    stage_t s;
    for (int c = 0; c < CHANNELS; c++) begin
      for (int k = 0; k < KERNEL_SIZE-1; k++) begin
        s[c][k] = s_in[c][k+1];
      end
      s[c][KERNEL_SIZE-1] = '0;
    end
    return s;
  endfunction

  assign is_last = (word_idx_q == LAST_IDX);

  // A new group is only taken when the current one is about to leave, so flush and
  // downstream stalls both block acceptance.
  always_comb begin
    in_ready = 1'b0;
    if (!flush) begin
      if (state_q == IDLE) in_ready = 1'b1;
      else                 in_ready = bus.out_ready && is_last;
    end
  end

  assign load = bus.in_valid && in_ready;
  assign pop  = out_valid_q && bus.out_ready;

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    word_idx_d  = word_idx_q;
    group_cnt_d = group_cnt_q;
    stage_d     = stage_q;

    if (flush) begin
      state_d     = IDLE;
      out_valid_d = 1'b0;
      word_idx_d  = '0;
      group_cnt_d = '0;
      stage_d     = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (load) begin
            stage_d     = unpack_group(bus.data_in);
            word_idx_d  = '0;
            state_d     = SHIFT;
            out_valid_d = 1'b1;
          end
        end
        SHIFT: begin
          if (pop) begin
            if (is_last) begin
              group_cnt_d = (group_cnt_q == LAST_GRP) ? '0 : group_cnt_q + 1'b1;
              word_idx_d  = '0;
              if (load) begin
                stage_d = unpack_group(bus.data_in);
              end else begin
                stage_d     = shift_down(stage_q);
                state_d     = IDLE;
                out_valid_d = 1'b0;
              end
            end else begin
              stage_d    = shift_down(stage_q);
              word_idx_d = word_idx_q + 1'b1;
            end
          end
        end
        default: begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      word_idx_q  <= '0;
      group_cnt_q <= '0;
      stage_q     <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      word_idx_q  <= word_idx_d;
      group_cnt_q <= group_cnt_d;
      stage_q     <= stage_d;
    end
  end

  always_comb begin
    bus.data_out = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      bus.data_out[c*DATA_WIDTH +: DATA_WIDTH] = stage_q[c][0];
    end
  end

  assign bus.in_ready     = in_ready;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_first    = out_valid_q && (word_idx_q == '0);
  assign bus.out_last     = out_valid_q && is_last;
  assign bus.out_row_last = bus.out_last && (group_cnt_q == LAST_GRP);
  assign dbg_state        = (state_q == SHIFT);

endmodule

// File: tb/tb_pooling_input_serializer.sv
// Directed bench: a K=2/C=1 row-of-3 instance and a K=3/C=4 instance, checked against hand-derived words and flags.
module tb_pooling_input_serializer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush0 = 1'b0;
  logic flush1 = 1'b0;
  logic dbg0, dbg1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pooling_input_serializer_if #(.DATA_WIDTH(32), .KERNEL_SIZE(2), .CHANNELS(1)) b0 ();
  pooling_input_serializer_if #(.DATA_WIDTH(32), .KERNEL_SIZE(3), .CHANNELS(4)) b1 ();

  pooling_input_serializer #(
    .DATA_WIDTH(32), .KERNEL_SIZE(2), .CHANNELS(1), .INPUT_SIZE(6)
  ) u0 (
    .clk(clk), .rst_n(rst_n), .flush(flush0), .bus(b0), .dbg_state(dbg0)
  );

  pooling_input_serializer #(
    .DATA_WIDTH(32), .KERNEL_SIZE(3), .CHANNELS(4), .INPUT_SIZE(6)
  ) u1 (
    .clk(clk), .rst_n(rst_n), .flush(flush1), .bus(b1), .dbg_state(dbg1)
  );

  task automatic check_eq(input string tag, input logic [383:0] got, input logic [383:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  function automatic logic [31:0] wd(input int g, input int k);
    return 32'h100 + 32'(2*g + k);
  endfunction

  function automatic logic [63:0] grp(input int g);
    return {wd(g, 0), wd(g, 1)};
  endfunction

  // One accepted output word on u0, then advance a cycle.
  task automatic chk_word(input logic [31:0] d, input logic first, input logic last,
                          input logic row_last, input logic rdy);
    settle();
    check_eq("w_valid", b0.out_valid, 1'b1);
    check_eq("w_data", b0.data_out, d);
    check_eq("w_first", b0.out_first, first);
    check_eq("w_last", b0.out_last, last);
    check_eq("w_row_last", b0.out_row_last, row_last);
    check_eq("w_in_ready", b0.in_ready, rdy);
    step();
  endtask

  // Three groups back-to-back with in_valid held: six words, no bubble, row_last on word 6.
  task automatic run_row(input int g);
    b0.in_valid = 1'b1;
    b0.data_in  = grp(g);
    settle();
    check_eq("row_in_ready", b0.in_ready, 1'b1);
    step();
    b0.data_in = grp(g+1);
    chk_word(wd(g, 0), 1'b1, 1'b0, 1'b0, 1'b0);
    chk_word(wd(g, 1), 1'b0, 1'b1, 1'b0, 1'b1);
    b0.data_in = grp(g+2);
    chk_word(wd(g+1, 0), 1'b1, 1'b0, 1'b0, 1'b0);
    chk_word(wd(g+1, 1), 1'b0, 1'b1, 1'b0, 1'b1);
    b0.in_valid = 1'b0;
    chk_word(wd(g+2, 0), 1'b1, 1'b0, 1'b0, 1'b0);
    chk_word(wd(g+2, 1), 1'b0, 1'b1, 1'b1, 1'b1);
    settle();
    check_eq("row_end_valid", b0.out_valid, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [383:0] d1;
    logic [127:0] e1;

    b0.in_valid = 1'b0; b0.data_in = '0; b0.out_ready = 1'b1;
    b1.in_valid = 1'b0; b1.data_in = '0; b1.out_ready = 1'b1;

    // Reset state
    #12;
    check_eq("rst_valid", b0.out_valid, 1'b0);
    check_eq("rst_data", b0.data_out, 32'h0);
    check_eq("rst_first", b0.out_first, 1'b0);
    check_eq("rst_last", b0.out_last, 1'b0);
    rst_n = 1'b1;
    step();
    check_eq("rel_in_ready", b0.in_ready, 1'b1);
    check_eq("rel_valid", b0.out_valid, 1'b0);

    // Single group
    b0.in_valid = 1'b1;
    b0.data_in  = 64'h3F800000_40000000;
    settle();
    check_eq("single_in_ready", b0.in_ready, 1'b1);
    step();
    b0.in_valid = 1'b0;
    chk_word(32'h3F800000, 1'b1, 1'b0, 1'b0, 1'b0);
    chk_word(32'h40000000, 1'b0, 1'b1, 1'b0, 1'b1);
    settle();
    check_eq("single_end_valid", b0.out_valid, 1'b0);
    check_eq("single_end_data", b0.data_out, 32'h0);

    // Flush while idle clears group_cnt and blocks acceptance
    flush0 = 1'b1;
    settle();
    check_eq("flush_idle_in_ready", b0.in_ready, 1'b0);
    step();
    flush0 = 1'b0;

    run_row(0);

    // Backpressure on word 0
    b0.in_valid = 1'b1;
    b0.data_in  = grp(3);
    step();
    b0.in_valid  = 1'b0;
    b0.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      check_eq("bp_valid", b0.out_valid, 1'b1);
      check_eq("bp_data", b0.data_out, wd(3, 0));
      check_eq("bp_first", b0.out_first, 1'b1);
      check_eq("bp_in_ready", b0.in_ready, 1'b0);
      step();
    end
    b0.out_ready = 1'b1;
    chk_word(wd(3, 0), 1'b1, 1'b0, 1'b0, 1'b0);
    chk_word(wd(3, 1), 1'b0, 1'b1, 1'b0, 1'b1);
    settle();
    check_eq("bp_end_valid", b0.out_valid, 1'b0);

    // Second group of the row, then flush mid-group of the third
    b0.in_valid = 1'b1;
    b0.data_in  = grp(4);
    step();
    b0.in_valid = 1'b0;
    chk_word(wd(4, 0), 1'b1, 1'b0, 1'b0, 1'b0);
    chk_word(wd(4, 1), 1'b0, 1'b1, 1'b0, 1'b1);
    b0.in_valid = 1'b1;
    b0.data_in  = grp(5);
    step();
    flush0 = 1'b1;
    b0.data_in = grp(6);
    settle();
    check_eq("flush_in_ready", b0.in_ready, 1'b0);
    check_eq("flush_cycle_valid", b0.out_valid, 1'b1);
    step();
    flush0 = 1'b0;
    b0.in_valid = 1'b0;
    settle();
    check_eq("flush_valid", b0.out_valid, 1'b0);
    check_eq("flush_data", b0.data_out, 32'h0);
    check_eq("flush_dbg_state", dbg0, 1'b0);
    step();
    check_eq("flush_drop_valid", b0.out_valid, 1'b0);

    run_row(7);

    // Async reset mid-group
    b0.in_valid = 1'b1;
    b0.data_in  = grp(10);
    step();
    b0.in_valid = 1'b0;
    settle();
    check_eq("pre_rst_valid", b0.out_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_valid", b0.out_valid, 1'b0);
    check_eq("mid_rst_data", b0.data_out, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check_eq("post_rst_in_ready", b0.in_ready, 1'b1);
    for (int i = 0; i < 3; i++) begin
      check_eq("post_rst_valid", b0.out_valid, 1'b0);
      step();
    end

    // Multi-channel lockstep, two groups back-to-back (second ends the row)
    d1 = '0;
    for (int c = 0; c < 4; c++)
      for (int k = 0; k < 3; k++)
        d1[c*96 + (2-k)*32 +: 32] = 32'(3*c + k);
    b1.in_valid = 1'b1;
    b1.data_in  = d1;
    settle();
    check_eq("mc_in_ready", b1.in_ready, 1'b1);
    step();
    for (int g = 0; g < 2; g++) begin
      for (int k = 0; k < 3; k++) begin
        for (int c = 0; c < 4; c++) e1[c*32 +: 32] = 32'(3*c + k);
        settle();
        check_eq("mc_valid", b1.out_valid, 1'b1);
        check_eq("mc_data", b1.data_out, e1);
        check_eq("mc_first", b1.out_first, k == 0);
        check_eq("mc_last", b1.out_last, k == 2);
        check_eq("mc_row_last", b1.out_row_last, (k == 2) && (g == 1));
        check_eq("mc_in_ready", b1.in_ready, k == 2);
        step();
        if (k == 2) b1.in_valid = 1'b0;
      end
    end
    settle();
    check_eq("mc_end_valid", b1.out_valid, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
